// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-issue integer register file with per-register busy scoreboard.
// Ports: per-lane Rs1/Rs2 read (data+busy), Wen/Rd_addr/write_data writeback, Rsv_en/Rsv_addr reserve, busy_vec.
module reg_file_sb #(
  parameter  int XLEN   = 64,
  parameter  int NREG   = 32,
  parameter  int ISSUE  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ISSUE*AW-1:0]   Rs1_addr,
  input  logic [ISSUE*AW-1:0]   Rs2_addr,
  output logic [ISSUE*XLEN-1:0] Rs1_data,
  output logic [ISSUE*XLEN-1:0] Rs2_data,
  output logic [ISSUE-1:0]      Rs1_busy,
  output logic [ISSUE-1:0]      Rs2_busy,
  input  logic [ISSUE-1:0]      Wen,
  input  logic [ISSUE*AW-1:0]   Rd_addr,
  input  logic [ISSUE*XLEN-1:0] write_data,
  input  logic [ISSUE-1:0]      Rsv_en,
  input  logic [ISSUE*AW-1:0]   Rsv_addr,
  output logic [NREG-1:0]       busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  // Returns {busy, data}; higher lanes override lower ones on a bypass hit.
  function automatic logic [XLEN:0] rport(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    logic            b;
    logic            hit;
    d   = regs[a];
    b   = busy[a];
    hit = 1'b0;
    if (BYPASS != 0) begin
      for (int l = 0; l < ISSUE; l++) begin
        if (Wen[l] && Rd_addr[l*AW +: AW] == a) begin
          d   = write_data[l*XLEN +: XLEN];
          hit = 1'b1;
        end
      end
    end
    if (hit) b = 1'b0;
    if (a == '0) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  always_comb begin
    Rs1_data = '0;
    Rs2_data = '0;
    Rs1_busy = '0;
    Rs2_busy = '0;
    for (int p = 0; p < ISSUE; p++) begin
      {Rs1_busy[p], Rs1_data[p*XLEN +: XLEN]} = rport(Rs1_addr[p*AW +: AW]);
      {Rs2_busy[p], Rs2_data[p*XLEN +: XLEN]} = rport(Rs2_addr[p*AW +: AW]);
    end
  end

  // Clears first, then sets: a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int l = 0; l < ISSUE; l++) begin
      if (Wen[l]) busy_nxt[Rd_addr[l*AW +: AW]] = 1'b0;
    end
    for (int l = 0; l < ISSUE; l++) begin
      if (Rsv_en[l]) busy_nxt[Rsv_addr[l*AW +: AW]] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Last NBA in lane order wins, giving the highest lane priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int l = 0; l < ISSUE; l++) begin
        if (Wen[l] && Rd_addr[l*AW +: AW] != '0) begin
          regs[Rd_addr[l*AW +: AW]] <= write_data[l*XLEN +: XLEN];
        end
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector bench for reg_file_sb.
// Covers bypass on/off (2 lanes) and a 4-lane build.
module tb_reg_file_sb;
  localparam int XL = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2*AW-1:0] rs1a, rs2a, rda, sva;
  logic [2*XL-1:0] wd;
  logic [1:0]      wen, rsv;
  logic [2*XL-1:0] a_rs1d, a_rs2d, b_rs1d, b_rs2d;
  logic [1:0]      a_rs1b, a_rs2b, b_rs1b, b_rs2b;
  logic [31:0]     a_bv, b_bv;

  logic [4*AW-1:0] c_rs1a, c_rs2a, c_rda, c_sva;
  logic [4*XL-1:0] c_wd, c_rs1d, c_rs2d;
  logic [3:0]      c_wen, c_rsv, c_rs1b, c_rs2b;
  logic [31:0]     c_bv;

  reg_file_sb #(.BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .Rs1_addr(rs1a), .Rs2_addr(rs2a),
    .Rs1_data(a_rs1d), .Rs2_data(a_rs2d),
    .Rs1_busy(a_rs1b), .Rs2_busy(a_rs2b),
    .Wen(wen), .Rd_addr(rda), .write_data(wd),
    .Rsv_en(rsv), .Rsv_addr(sva), .busy_vec(a_bv)
  );

  reg_file_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .Rs1_addr(rs1a), .Rs2_addr(rs2a),
    .Rs1_data(b_rs1d), .Rs2_data(b_rs2d),
    .Rs1_busy(b_rs1b), .Rs2_busy(b_rs2b),
    .Wen(wen), .Rd_addr(rda), .write_data(wd),
    .Rsv_en(rsv), .Rsv_addr(sva), .busy_vec(b_bv)
  );

  reg_file_sb #(.ISSUE(4), .BYPASS(1)) dut_c (
    .clk(clk), .rst(rst), .Rs1_addr(c_rs1a), .Rs2_addr(c_rs2a),
    .Rs1_data(c_rs1d), .Rs2_data(c_rs2d),
    .Rs1_busy(c_rs1b), .Rs2_busy(c_rs2b),
    .Wen(c_wen), .Rd_addr(c_rda), .write_data(c_wd),
    .Rsv_en(c_rsv), .Rsv_addr(c_sva), .busy_vec(c_bv)
  );

  typedef struct {
    string       nm;
    logic [1:0]  wen;
    logic [4:0]  rd0;
    logic [63:0] wd0;
    logic [4:0]  rd1;
    logic [63:0] wd1;
    logic [1:0]  rsv;
    logic [4:0]  s0, s1;
    logic [4:0]  r0, r1;
    logic [63:0] e0, e1;
    logic        eb0, eb1;
    logic [63:0] enb;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [14];

  function automatic vec_t mk(
    input string nm, input logic [1:0] w,
    input logic [4:0] rd0, input logic [63:0] wd0,
    input logic [4:0] rd1, input logic [63:0] wd1,
    input logic [1:0] rv, input logic [4:0] s0, input logic [4:0] s1,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [63:0] e0, input logic [63:0] e1,
    input logic eb0, input logic eb1, input logic [63:0] enb);
    vec_t v;
    v.nm = nm; v.wen = w; v.rd0 = rd0; v.wd0 = wd0;
    v.rd1 = rd1; v.wd1 = wd1; v.rsv = rv; v.s0 = s0; v.s1 = s1;
    v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
    v.eb0 = eb0; v.eb1 = eb1; v.enb = enb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    wen = '0; rsv = '0; rda = '0; sva = '0; wd = '0;
    rs1a = '0; rs2a = '0;
    c_wen = '0; c_rsv = '0; c_rda = '0; c_sva = '0; c_wd = '0;
    c_rs1a = '0; c_rs2a = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int l, input logic [4:0] r, input logic [63:0] d);
    wen[l] = 1'b1;
    rda[l*AW +: AW] = r;
    wd[l*XL +: XL] = d;
  endtask

  task automatic rs(input int l, input logic [4:0] r);
    rsv[l] = 1'b1;
    sva[l*AW +: AW] = r;
  endtask

  task automatic cwr(input int l, input logic [4:0] r, input logic [63:0] d);
    c_wen[l] = 1'b1;
    c_rda[l*AW +: AW] = r;
    c_wd[l*XL +: XL] = d;
  endtask

  task automatic crs(input int l, input logic [4:0] r);
    c_rsv[l] = 1'b1;
    c_sva[l*AW +: AW] = r;
  endtask

  initial begin
    tbl[0]  = mk("rst",    2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 1, 2, 0, 0, 0, 0, 0);
    tbl[1]  = mk("byp",    2'b11, 1, 'h11,     2, 'h22,     2'b00, 0, 0,
                 1, 2, 'h11, 'h22, 0, 0, 0);
    tbl[2]  = mk("rsv3",   2'b00, 0, 0,        0, 0,        2'b01, 3, 0,
                 1, 2, 'h11, 'h22, 0, 0, 'h11);
    tbl[3]  = mk("busy3",  2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 3, 1, 0, 'h11, 1, 0, 0);
    tbl[4]  = mk("wb3",    2'b10, 0, 0,        3, 'h33,     2'b00, 0, 0,
                 3, 3, 'h33, 'h33, 0, 0, 0);
    tbl[5]  = mk("post3",  2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 3, 0, 'h33, 0, 0, 0, 'h33);
    tbl[6]  = mk("x0",     2'b01, 0, 'hFFFF,   0, 0,        2'b10, 0, 0,
                 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk("x0hold", 2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 0, 1, 0, 'h11, 0, 0, 0);
    tbl[8]  = mk("conf",   2'b11, 9, 'hAAAA,   9, 'hBBBB,   2'b00, 0, 0,
                 9, 9, 'hBBBB, 'hBBBB, 0, 0, 0);
    tbl[9]  = mk("conf2",  2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 9, 9, 'hBBBB, 'hBBBB, 0, 0, 'hBBBB);
    tbl[10] = mk("coll",   2'b01, 13, 'h1313,  0, 0,        2'b10, 0, 13,
                 13, 13, 'h1313, 'h1313, 0, 0, 0);
    tbl[11] = mk("coll2",  2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 13, 13, 'h1313, 'h1313, 1, 1, 'h1313);
    tbl[12] = mk("rvw",    2'b10, 0, 0,        13, 'h99,    2'b01, 13, 0,
                 13, 13, 'h99, 'h99, 0, 0, 'h1313);
    tbl[13] = mk("rvw2",   2'b00, 0, 0,        0, 0,        2'b00, 0, 0,
                 13, 13, 'h99, 'h99, 1, 1, 'h99);

    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_bv_a", a_bv, 0);
    chk("rst_bv_b", b_bv, 0);
    chk("rst_bv_c", c_bv, 0);

    for (int i = 0; i < 14; i++) begin
      idle();
      wen = tbl[i].wen;
      rda = {tbl[i].rd1, tbl[i].rd0};
      wd  = {tbl[i].wd1, tbl[i].wd0};
      rsv = tbl[i].rsv;
      sva = {tbl[i].s1, tbl[i].s0};
      rs1a[4:0] = tbl[i].r0;
      rs2a[9:5] = tbl[i].r1;
      #1;
      chk({tbl[i].nm, "_d0"}, a_rs1d[63:0], tbl[i].e0);
      chk({tbl[i].nm, "_d1"}, a_rs2d[127:64], tbl[i].e1);
      chk({tbl[i].nm, "_b0"}, {63'd0, a_rs1b[0]}, {63'd0, tbl[i].eb0});
      chk({tbl[i].nm, "_b1"}, {63'd0, a_rs2b[1]}, {63'd0, tbl[i].eb1});
      chk({tbl[i].nm, "_nb"}, b_rs1d[63:0], tbl[i].enb);
      tick();
    end
    idle();
    #1;
    chk("tbl_bv_a", a_bv, 32'h0000_2000);

    // Scoreboard timing on x12
    idle(); rs(0, 12); rs1a[4:0] = 12; #1;
    chk("sb_n_busy", {63'd0, a_rs1b[0]}, 0);
    tick();
    idle(); rs1a[4:0] = 12; #1;
    chk("sb_n1_busy", {63'd0, a_rs1b[0]}, 1);
    chk("sb_n1_bv", {63'd0, a_bv[12]}, 1);
    tick();
    idle(); rs1a[4:0] = 12; #1;
    chk("sb_n2_busy", {63'd0, a_rs1b[0]}, 1);
    tick();
    idle(); wr(1, 12, 'h77); rs1a[4:0] = 12; #1;
    chk("sb_n3_data", a_rs1d[63:0], 'h77);
    chk("sb_n3_busy", {63'd0, a_rs1b[0]}, 0);
    chk("sb_n3_bv", {63'd0, a_bv[12]}, 1);
    chk("sb_n3_nb_data", b_rs1d[63:0], 0);
    chk("sb_n3_nb_busy", {63'd0, b_rs1b[0]}, 1);
    tick();
    idle(); rs1a[4:0] = 12; #1;
    chk("sb_n4_bv", {63'd0, a_bv[12]}, 0);
    chk("sb_n4_nb_data", b_rs1d[63:0], 'h77);
    chk("sb_n4_nb_busy", {63'd0, b_rs1b[0]}, 0);

    // Bypass off on x10
    idle(); wr(0, 10, 'h55); rs2a[9:5] = 10; #1;
    chk("nb_x10_now", b_rs2d[127:64], 0);
    chk("byp_x10_now", a_rs2d[127:64], 'h55);
    tick();
    idle(); rs2a[9:5] = 10; #1;
    chk("nb_x10_next", b_rs2d[127:64], 'h55);

    // Four-lane priority and collisions
    idle();
    cwr(0, 20, 'hA0); cwr(1, 20, 'hA1); cwr(3, 20, 'hA3);
    c_rs1a[2*AW +: AW] = 20; #1;
    chk("c_x20_byp", c_rs1d[2*XL +: XL], 'hA3);
    tick();
    idle(); c_rs2a[3*AW +: AW] = 20;
    cwr(0, 21, 'hB0); cwr(1, 21, 'hB1); cwr(2, 21, 'hB2); crs(3, 21);
    c_rs1a[0 +: AW] = 21; #1;
    chk("c_x20", c_rs2d[3*XL +: XL], 'hA3);
    chk("c_x21_byp", c_rs1d[0 +: XL], 'hB2);
    chk("c_x21_byp_busy", {63'd0, c_rs1b[0]}, 0);
    tick();
    idle(); c_rs1a[3*AW +: AW] = 21;
    cwr(3, 22, 'hC3); crs(0, 22); crs(2, 23); #1;
    chk("c_x21", c_rs1d[3*XL +: XL], 'hB2);
    chk("c_x21_busy", {63'd0, c_rs1b[3]}, 1);
    tick();
    idle(); c_rs1a[1*AW +: AW] = 22; #1;
    chk("c_x22", c_rs1d[1*XL +: XL], 'hC3);
    chk("c_bv", c_bv, 32'h00E0_0000);

    // Reset mid-operation
    idle(); wr(0, 5, 'h1234); rs(1, 6);
    tick();
    idle(); rs1a[4:0] = 5; rs2a[9:5] = 6; #1;
    chk("pre_x5", a_rs1d[63:0], 'h1234);
    chk("pre_x6_busy", {63'd0, a_rs2b[1]}, 1);
    rst = 1'b1; wr(0, 7, 'h77); rs(1, 8);
    tick();
    rst = 1'b0;
    idle(); rs1a[4:0] = 5; rs2a[9:5] = 7; #1;
    chk("post_x5", a_rs1d[63:0], 0);
    chk("post_x7", a_rs2d[127:64], 0);
    chk("post_bv_a", a_bv, 0);
    chk("post_bv_b", b_bv, 0);
    chk("post_bv_c", c_bv, 0);
    chk("post_nb_x5", b_rs1d[63:0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-issue integer register file with a per-register busy scoreboard for the superscalar RISC-V core. It sits between decode/issue (reads, reservations) and writeback (writes). It generalises the fixed 2-lane, 64-bit register file: any lane count, x0 hardwired to zero, deterministic same-address write priority, optional write-to-read bypass, synchronous reset clear, and RAW hazard tracking via busy bits.

## Interface
- XLEN, 64, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- ISSUE, 2, number of lanes; each lane has 2 read ports, 1 write port, 1 reserve port
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only
- AW, $clog2(NREG), address width (derived, not overridable)

Ports (lane l occupies slice [l*W +: W]):
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- Rs1_addr  in  ISSUE*AW  source-1 address per lane
- Rs2_addr  in  ISSUE*AW  source-2 address per lane
- Rs1_data  out  ISSUE*XLEN  source-1 data per lane
- Rs2_data  out  ISSUE*XLEN  source-2 data per lane
- Rs1_busy  out  ISSUE  source-1 register has an outstanding producer
- Rs2_busy  out  ISSUE  source-2 register has an outstanding producer
- Wen  in  ISSUE  write enable per lane (writeback)
- Rd_addr  in  ISSUE*AW  write address per lane
- write_data  in  ISSUE*XLEN  write data per lane
- Rsv_en  in  ISSUE  reserve destination (instruction issued) per lane
- Rsv_addr  in  ISSUE*AW  reserved destination address per lane
- busy_vec  out  NREG  current registered busy bits (debug/issue logic)

## Operation
- Storage: NREG×XLEN array plus NREG-bit busy vector; register 0 is never written and never busy.
- Reads (combinational): data = 0 if addr==0; else if BYPASS and some lane l has Wen[l] && Rd_addr[l]==addr, data = write_data of the highest such l; else array[addr].
- Busy outputs: Rsx_busy = busy[addr] && addr!=0, forced 0 when BYPASS and a same-cycle write hits addr (value is being delivered now). With BYPASS=0 a same-cycle write does not clear the read-side busy.
- Writes (posedge): for each lane with Wen && Rd_addr!=0, array[Rd_addr] <= write_data. Same address on multiple lanes: highest lane index wins (later in program order). Other lanes unaffected.
- Scoreboard next state per register r≠0: set if any Rsv_en[l] && Rsv_addr[l]==r; else clear if any Wen[l] && Rd_addr[l]==r; else hold. Reserve beats write on the same register in the same cycle (new producer supersedes the retiring one).
- Reserve of x0 ignored. Reserving an already busy register keeps it busy (no count; only the latest producer is tracked; issue logic guarantees WAW ordering).
- Reset: when rst=1 at a rising edge, all registers <= 0 and busy <= 0; Wen and Rsv_en in that cycle are ignored. No test preload values.

## Timing
- Read latency 0 (combinational from addresses, array, and—if BYPASS—write ports).
- Write visible in array one cycle after the Wen edge; visible same cycle only via bypass.
- Busy set visible on Rsx_busy/busy_vec the cycle after Rsv_en; cleared the cycle after Wen (same cycle on read ports when BYPASS=1).
- Output reset values after a reset edge: Rs*_data = 0 for all addresses, Rs*_busy = 0, busy_vec = 0.
- Reset asserted mid-operation discards all in-flight writes/reservations of that cycle; deassertion needs no recovery cycles.

## Test plan
- Reset: preload x5=0x1234 and reserve x6, assert rst 1 cycle -> all reads 0, busy_vec=0; Wen during rst cycle to x7 leaves x7=0.
- x0: Wen lane0 Rd=0 data=0xFFFF, Rsv x0 -> Rs1_data(addr 0)=0, busy_vec[0]=0.
- Write conflict: lane0 and lane1 both write x9 (0xAAAA, 0xBBBB) -> next cycle x9=0xBBBB; with BYPASS=1 same-cycle read of x9 returns 0xBBBB.
- Bypass off (BYPASS=0): write x10=0x55 and read x10 same cycle -> old value 0; next cycle 0x55.
- Scoreboard: Rsv x12 at cycle n -> Rs1_busy=1 from n+1; Wen x12=0x77 at n+3 -> (BYPASS=1) busy 0 and data 0x77 in n+3, busy_vec[12]=0 at n+4.
- Reserve/write collision: lane0 Wen x13 and lane1 Rsv x13 same cycle -> x13 takes write data, busy_vec[13]=1 next cycle; ISSUE=4 build repeats conflict/priority checks on lanes 0–3.
